// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) priority encoder with fixed (MSB-first) or round-robin
// arbitration, a valid/ready output stage, a one-hot grant and a multi-request flag.
module prio_enc_rr #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     grant,
    output logic             multi
);

    logic [IDX_W-1:0] ptr;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] fixed_win;
    logic [IDX_W-1:0] rr_off;
    logic [IDX_W-1:0] win;
    logic [N-1:0]     win_onehot;
    logic             multi_c;
    logic             load;

    assign load    = !out_valid || out_ready;
    assign multi_c = |(req & (req - N'(1)));

    // Requests rotated so that bit 0 of rot is the line at ptr; the lowest set
    // bit of rot is then the first requester found searching upward from ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rot        = '0;
        fixed_win  = '0;
        rr_off     = '0;
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[ptr + IDX_W'(i)];
        end
        for (int i = 0; i < N; i++) begin
            if (req[i]) fixed_win = IDX_W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rr_off = IDX_W'(i);
        end
        win             = mode ? ptr + rr_off : fixed_win;
        win_onehot[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            out_valid <= 1'b0;
            idx       <= '0;
            grant     <= '0;
            multi     <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            if (|req) begin
                out_valid <= 1'b1;
                idx       <= win;
                grant     <= win_onehot;
                multi     <= multi_c;
                if (mode) ptr <= win + IDX_W'(1);
            end else begin
                // idx and multi are left as-is; they are don't-care while invalid.
                out_valid <= 1'b0;
                grant     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed, table-driven bench for prio_enc_rr (N=8) with hand-written
// sequences for backpressure and reset during a stall.
module tb_prio_enc_rr;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     grant;
    logic             multi;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic             rst_n;
        logic             mode;
        logic             rdy;
        logic [N-1:0]     req;
        logic             exp_v;
        logic [IDX_W-1:0] exp_idx;
        logic [N-1:0]     exp_g;
        logic             exp_m;
        logic             chk_im;   // idx/multi are don't-care when invalid
    } vec_t;

    vec_t vecs[$];

    prio_enc_rr #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .grant     (grant),
        .multi     (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic m, input logic rd,
                                input logic [N-1:0] rq, input logic v,
                                input logic [IDX_W-1:0] ix, input logic [N-1:0] g,
                                input logic mu, input logic ci);
        vec_t t;
        t.rst_n = r;  t.mode = m;    t.rdy = rd;  t.req = rq;
        t.exp_v = v;  t.exp_idx = ix; t.exp_g = g; t.exp_m = mu; t.chk_im = ci;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [IDX_W-1:0] ix,
                             input logic [N-1:0] g, input logic mu, input logic ci);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".grant"},     32'(grant),     32'(g));
        if (ci) begin
            check({tag, ".idx"},   32'(idx),       32'(ix));
            check({tag, ".multi"}, 32'(multi),     32'(mu));
        end
    endtask

    initial begin
        bit found;

        // Reset held two cycles with all requests asserted.
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 1));
        // Round-robin sweep from ptr=0: 0..7,0,1.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 1, 1, 8'hFF, 1, IDX_W'(i % N), N'(1) << (i % N), 1, 1));
        // Fixed priority; ptr stays at 2.
        vecs.push_back(mk(1, 0, 1, 8'b1010_0000, 1, 7, 8'h80, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'b0000_0001, 1, 0, 8'h01, 0, 1));
        vecs.push_back(mk(1, 0, 1, 8'h00,        0, 0, 8'h00, 0, 0));
        // Round-robin with gaps from ptr=2, then fixed mode.
        vecs.push_back(mk(1, 1, 1, 8'b0100_0100, 1, 2, 8'h04, 1, 1));
        vecs.push_back(mk(1, 1, 1, 8'b0100_0100, 1, 6, 8'h40, 1, 1));
        vecs.push_back(mk(1, 1, 1, 8'b0100_0100, 1, 2, 8'h04, 1, 1));
        vecs.push_back(mk(1, 1, 1, 8'b0100_0100, 1, 6, 8'h40, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'b0100_0100, 1, 6, 8'h40, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'b0100_0100, 1, 6, 8'h40, 1, 1));
        // Single requester at N-1 in RR (ptr=7): repeats, pointer wraps to 0.
        vecs.push_back(mk(1, 1, 1, 8'h80, 1, 7, 8'h80, 0, 1));
        vecs.push_back(mk(1, 1, 1, 8'h80, 1, 7, 8'h80, 0, 1));
        vecs.push_back(mk(1, 1, 1, 8'hFF, 1, 0, 8'h01, 1, 1));

        rst_n = 1'b0; mode = 1'b1; out_ready = 1'b1; req = 8'hFF;

        foreach (vecs[k]) begin
            rst_n     = vecs[k].rst_n;
            mode      = vecs[k].mode;
            out_ready = vecs[k].rdy;
            req       = vecs[k].req;
            step();
            check_out($sformatf("vec%0d", k), vecs[k].exp_v, vecs[k].exp_idx,
                      vecs[k].exp_g, vecs[k].exp_m, vecs[k].chk_im);
        end

        // Backpressure: run RR until idx=2 is granted (ptr is 1 here), then stall.
        mode = 1'b1; out_ready = 1'b1; req = 8'hFF;
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            step();
            if (out_valid && idx == 3'd2) found = 1'b1;
        end
        check("bp.reach_idx2", 32'(found), 32'(1));
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_out($sformatf("bp.stall%0d", c), 1, 2, 8'h04, 1, 1);
            req  = 8'h01;   // changes during the stall must not leak through
            mode = 1'b0;
        end
        req = 8'hFF; mode = 1'b1; out_ready = 1'b1;
        step();
        check_out("bp.release", 1, 3, 8'h08, 1, 1);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        step();
        check_out("rs.hold", 1, 3, 8'h08, 1, 1);
        rst_n = 1'b0;
        step();
        check_out("rs.reset", 0, 0, 8'h00, 0, 1);
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        check_out("rs.first", 1, 0, 8'h01, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised, registered N-to-log2(N) priority encoder. It is the successor to the fixed 4-to-2 combinational encoder. It adds a selectable round-robin mode, a registered output with a valid/ready handshake, a one-hot grant and a multi-request flag. It sits between a bank of N request lines and a single downstream consumer, such as a channel-select mux or a service FSM.

## Interface
Parameters:
- `N`, default 8: number of request lines; must be a power of two, N ≥ 2.
- `IDX_W`, default 3: width of the encoded index; must equal log2(N).

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req`, input, N: request vector. Requesters hold their bit until served; the block never clears it.
- `mode`, input, 1: 0 = fixed priority (highest index wins); 1 = round-robin.
- `out_valid`, output, 1: output register holds a valid encoding.
- `out_ready`, input, 1: consumer accepts the current output.
- `idx`, output, IDX_W: encoded index of the granted request.
- `grant`, output, N: one-hot form of `idx`; all-zero when `out_valid` = 0.
- `multi`, output, 1: more than one `req` bit was set when the output was captured.

## Operation
- **Load condition:** `load = (!out_valid || out_ready)`.
- **Capture on load, `req` nonzero:**
  - `idx` takes the winner, `grant` takes 1 << winner, and `multi` takes (popcount(req) > 1).
  - `out_valid` is set to 1.
- **Load, `req` all zero:**
  - `out_valid` is set to 0; `grant` is set to 0.
  - `idx` and `multi` hold their previous values; these are don't-care while invalid.
- **No load (`out_valid` = 1 and `out_ready` = 0):** every output holds, regardless of `req` or `mode` changes.
- **Winner selection, fixed mode (`mode` = 0):** highest set index wins. Example: 4'b1010 gives 3. This matches the legacy encoder's MSB priority.
- **Winner selection, round-robin mode (`mode` = 1):**
  - Search starts at the internal pointer `ptr`, then ptr+1, and so on upward, wrapping modulo N.
  - The first set bit wins.
- **Pointer `ptr` (IDX_W bits):**
  - On every capture in RR mode, `ptr` ← (winner + 1) mod N. Wrap is natural for power-of-two N.
  - Captures in fixed mode do not change `ptr`.
  - Switching `mode` does not change `ptr`.
- **Request timing:** `req` is sampled only in load cycles. A request asserted and then dropped during a stall is lost; this is by design.

## Timing
- **Reset** (`rst_n` = 0 at a rising edge, with priority over everything):
  - `out_valid` = 0, `grant` = 0, `idx` = 0, `multi` = 0, `ptr` = 0.
- **Latency:** `req` sampled at edge t appears on `idx`/`grant`/`out_valid` after edge t, i.e. one cycle.
- **Throughput:** one grant per cycle while `out_ready` = 1.
- **Handshake:**
  - A transfer occurs on an edge where `out_valid` && `out_ready`.
  - While `out_valid` = 1 and `out_ready` = 0, all outputs must be stable.
  - `out_ready` may be high while `out_valid` = 0; this has no effect.
- **Transfer and capture in the same edge:** the new capture replaces the output with no bubble.
- **Reset during a stall:** the pending output is discarded; `out_valid` = 0 on the next cycle. The first capture after reset in RR mode searches from index 0.
- **Single requester in RR mode:** the same index wins repeatedly. `ptr` moves to index+1 each time, with no starvation artefacts.
- **Requester at index N-1 wins in RR mode:** `ptr` wraps to 0.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n` = 0 for 2 cycles with `req` = 8'hFF.
  - Required: `out_valid`, `grant`, `idx` and `multi` all 0 throughout. After release with `mode` = 1 and `out_ready` = 1, the first `idx` is 0.
- **Fixed priority:**
  - Stimulus: `mode` = 0, `out_ready` = 1; `req` = 8'b1010_0000, then 8'b0000_0001, then 8'h00.
  - Required, per cycle:
    - `idx` = 7, `grant` = 8'h80, `multi` = 1.
    - then `idx` = 0, `grant` = 8'h01, `multi` = 0.
    - then `out_valid` = 0, `grant` = 0.
- **Round-robin sweep:**
  - Stimulus: `mode` = 1, `req` = 8'hFF, `out_ready` = 1 for 10 cycles.
  - Required: `idx` sequence 0,1,…,7,0,1, each with `multi` = 1.
- **Round-robin with gaps:**
  - Stimulus: `mode` = 1, `req` = 8'b0100_0100.
  - Required: `idx` alternates 2,6,2,6. Then switch `mode` to 0: `idx` = 6 every cycle.
- **Backpressure:**
  - Stimulus: `mode` = 1, `req` = 8'hFF; drop `out_ready` for 3 cycles after the grant of `idx` = 2.
  - Required: `idx` = 2 and `out_valid` = 1 held for the whole stall. On release, the next `idx` is 3.
- **Reset mid-stall:**
  - Stimulus: `out_valid` = 1 with `out_ready` = 0; pulse `rst_n` low for one edge.
  - Required: the next cycle has `out_valid` = 0. The following RR grant with `req` = 8'hFF is `idx` = 0.
